// File: rtl/pot_pkg.sv
// Shared definitions for the power-of-two weight path: encoder FSM states,
// exponent range and {sign, exp} code-field helpers used by encoder and multiplier.
package pot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } pot_state_t;

    // Largest exponent representable in a code of the given total width.
    function automatic int pot_emax(input int weight_bit_width);
        return (1 << (weight_bit_width - 1)) - 1;
    endfunction

    function automatic int pot_sign_idx(input int weight_bit_width);
        return weight_bit_width - 1;
    endfunction

    // Exponent occupies [pot_exp_msb : 0] of the code.
    function automatic int pot_exp_msb(input int weight_bit_width);
        return weight_bit_width - 2;
    endfunction

endpackage

// File: rtl/pot_encoder.sv
// Sequential power-of-two quantizer: signed Q1.(V-1) value -> {sign, exp} code via
// a one-bit-per-cycle leading-one search. Define POT_ROUND_EN for round-to-nearest.
module pot_encoder
    import pot_pkg::*;
#(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int VALUE_BIT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [VALUE_BIT_WIDTH-1:0]  in_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WEIGHT_BIT_WIDTH-1:0] out_weight
);

    localparam int V  = VALUE_BIT_WIDTH;
    localparam int EW = pot_exp_msb(WEIGHT_BIT_WIDTH) + 1;
    localparam logic [EW-1:0] EMAX = EW'(pot_emax(WEIGHT_BIT_WIDTH));

    pot_state_t                  state_reg, state_next;
    logic [V-1:0]                mag_reg, mag_next;
    logic [EW-1:0]               cnt_reg, cnt_next;
    logic                        sign_reg, sign_next;
    logic [WEIGHT_BIT_WIDTH-1:0] out_weight_reg, out_weight_next;

    logic [V-1:0]  in_mag;
    logic          found;
    logic [EW-1:0] exp_sel;

    // Two's-complement magnitude; the most negative value maps to 2^(V-1).
    assign in_mag = in_value[V-1] ? (~in_value + V'(1)) : in_value;
    assign found  = mag_reg[V-1] | (cnt_reg == EMAX);

`ifdef POT_ROUND_EN
    // Round up when the bit below the leading one is set; a clamped search is never rounded.
    assign exp_sel = (mag_reg[V-1] && mag_reg[V-2] && (cnt_reg != '0)) ?
                     (cnt_reg - EW'(1)) : cnt_reg;
`else
    assign exp_sel = cnt_reg;
`endif

    always_comb begin
        state_next      = state_reg;
        mag_next        = mag_reg;
        cnt_next        = cnt_reg;
        sign_next       = sign_reg;
        out_weight_next = out_weight_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_next  = in_value[V-1];
                    mag_next   = in_mag;
                    cnt_next   = '0;
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (found) begin
                    // Zero input has no sign; a nonzero magnitude stays nonzero while shifting.
                    out_weight_next = {sign_reg & (|mag_reg), exp_sel};
                    state_next      = DONE;
                end else begin
                    mag_next = mag_reg << 1;
                    cnt_next = cnt_reg + EW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mag_reg        <= '0;
            cnt_reg        <= '0;
            sign_reg       <= 1'b0;
            out_weight_reg <= '0;
        end else begin
            state_reg      <= state_next;
            mag_reg        <= mag_next;
            cnt_reg        <= cnt_next;
            sign_reg       <= sign_next;
            out_weight_reg <= out_weight_next;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_weight = out_weight_reg;

endmodule

// File: tb/tb_pot_encoder.sv
// Randomized and directed bench for pot_encoder against a value-domain PoT reference.
module tb_pot_encoder;

    localparam int V    = 8;
    localparam int W    = 4;
    localparam int EMAX = (1 << (W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [V-1:0] in_value = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_weight;

    int total = 0;
    int bad   = 0;

    pot_encoder #(.WEIGHT_BIT_WIDTH(W), .VALUE_BIT_WIDTH(V)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_weight (out_weight)
    );

    always #5 clk = ~clk;

    // Reference: nearest power of two at or below |v| (exponent clamped to EMAX),
    // optionally rounded up to the next power when |v| >= 1.5 * that power.
    function automatic void model(input logic [V-1:0] v, output logic [W-1:0] code,
                                  output int lat);
        int  m;
        int  l;
        int  e;
        bit  neg;
        bit  clamp;
        m     = int'($signed(v));
        neg   = (m < 0);
        if (neg) m = -m;
        l     = EMAX;
        clamp = 1'b1;
        for (int k = 0; k <= EMAX; k++) begin
            if (clamp && m >= (1 << (V - 1 - k))) begin
                l     = k;
                clamp = 1'b0;
            end
        end
        e = l;
`ifdef POT_ROUND_EN
        if (!clamp && l > 0 && 2 * m >= 3 * (1 << (V - 1 - l))) e = l - 1;
`endif
        code = {neg, 3'(e)};
        lat  = l + 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, measure latency, apply back-pressure, handshake.
    task automatic run_one(input logic [V-1:0] v, input int hold);
        logic [W-1:0] exp_code;
        int           exp_lat;
        int           lat;
        int           waited;
        logic [W-1:0] first_w;
        model(v, exp_code, exp_lat);
        waited = 0;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout value=%02h in_ready=%b required=1", v, in_ready);
            return;
        end
        in_valid = 1'b1;
        in_value = v;
        step();
        in_valid = 1'b0;
        in_value = $urandom_range(0, 255);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL latency value=%02h got=%0d required=%0d", v, lat, exp_lat);
        end
        total++;
        if (out_weight !== exp_code) begin
            bad++;
            $display("FAIL code value=%02h got=%b required=%b", v, out_weight, exp_code);
        end
        first_w = out_weight;
        for (int i = 0; i < hold; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_weight !== first_w || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold value=%02h valid=%b weight=%b in_ready=%b required valid=1 weight=%b in_ready=0",
                         v, out_valid, out_weight, in_ready, first_w);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = $urandom_range(0, 1);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake value=%02h valid=%b in_ready=%b required valid=0 in_ready=1",
                     v, out_valid, in_ready);
        end
        out_ready = 1'b0;
        $display("txn value=%02h weight=%b latency=%0d hold=%0d", v, first_w, lat, hold);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_weight !== '0) begin
            bad++;
            $display("FAIL reset in_ready=%b out_valid=%b out_weight=%b required 1 0 0000",
                     in_ready, out_valid, out_weight);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] req;
        run_one(8'h20, 0);
        total++;
        if (out_weight !== 4'b0010) begin
            bad++;
            $display("FAIL quarter got=%b required=0010", out_weight);
        end
        run_one(8'hE0, 0);
        total++;
        if (out_weight !== 4'b1010) begin
            bad++;
            $display("FAIL neg_quarter got=%b required=1010", out_weight);
        end
        run_one(8'h80, 0);
        total++;
        if (out_weight !== 4'b1000) begin
            bad++;
            $display("FAIL minus_one got=%b required=1000", out_weight);
        end
        run_one(8'h00, 0);
        total++;
        if (out_weight !== 4'b0111) begin
            bad++;
            $display("FAIL zero got=%b required=0111", out_weight);
        end
        run_one(8'h30, 0);
`ifdef POT_ROUND_EN
        req = 4'b0001;
`else
        req = 4'b0010;
`endif
        total++;
        if (out_weight !== req) begin
            bad++;
            $display("FAIL round_0x30 got=%b required=%b", out_weight, req);
        end
    endtask

    task automatic test_backpressure();
        run_one(8'h90, 5);
        run_one(8'h01, 5);
    endtask

    task automatic test_back_to_back();
        run_one(8'h7F, 0);
        run_one(8'h40, 0);
        run_one(8'hFF, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_one(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1;
        in_value = 8'h01;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_weight !== '0) begin
            bad++;
            $display("FAIL abort_reset out_valid=%b in_ready=%b out_weight=%b required 0 1 0000",
                     out_valid, in_ready, out_weight);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_idle cycle=%0d out_valid=%b in_ready=%b required 0 1",
                         i, out_valid, in_ready);
            end
        end
        $display("txn value=01 aborted by reset");
        run_one(8'h08, 1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pot_encoder.md
# pot_encoder

Sequential power-of-two quantizer: converts a signed fixed-point value into the sign/exponent weight code consumed by the PoT shift multiplier, where code `{s, e}` represents (−1)^s · 2^−e. It sits on the weight-preparation path, between a trained or streamed full-precision weight source and the PoT weight memory. The exponent is found by an iterative leading-one search, one bit per cycle, behind valid/ready handshakes on both sides.

## Interface
- `WEIGHT_BIT_WIDTH`, default 4: width of the output code.
  - The MSB is the sign.
  - The lower `WEIGHT_BIT_WIDTH-1` bits are the exponent `e`.
- `VALUE_BIT_WIDTH`, default 8: width of the input value, signed two's complement, Q1.(`VALUE_BIT_WIDTH`−1), range [−1, 1).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_value` is valid.
- `in_ready` output 1: the block can accept an input.
- `in_value` input `VALUE_BIT_WIDTH`, signed: value to encode.
- `out_valid` output 1: `out_weight` is valid.
- `out_ready` input 1: the consumer accepts `out_weight`.
- `out_weight` output `WEIGHT_BIT_WIDTH`: PoT code `{sign, exp}`.

## Operation
- Definitions:
  - EMAX = 2^(`WEIGHT_BIT_WIDTH`−1) − 1.
  - V = `VALUE_BIT_WIDTH`.
- State machine with three states: IDLE, SEARCH, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch:
    - sign = `in_value[V-1]`;
    - mag = |`in_value`| as V-bit unsigned (−2^(V−1) gives mag = 2^(V−1));
    - cnt = 0.
  - Go to SEARCH.
- SEARCH, evaluated each cycle:
  - If `mag[V-1]` = 1 or cnt = EMAX: set exp = cnt, go to DONE.
  - Otherwise: mag <<= 1, cnt += 1.
- DONE:
  - `out_valid` = 1 and `out_weight` = {sign_o, exp}.
  - Outputs are held stable until `out_ready`; on `out_valid & out_ready`, go to IDLE.
- Zero input (mag = 0): search clamps at EMAX; the code is sign_o = 0, exp = EMAX. There is no zero code.
- Magnitudes below 2^−EMAX clamp to exp = EMAX with the input sign preserved.
- sign_o = sign, except for zero input, where sign_o = 0.
- `in_ready` is 0 in SEARCH and DONE. Inputs are not overlapped: at most one value is in flight.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `out_weight` = 0, internal mag/cnt/sign = 0.
- Let L = clamped leading-one count (the cnt value at SEARCH exit). If the input is accepted in cycle c0, `out_valid` first rises in cycle c0+L+2.
- Minimum latency is 2 (exp 0). Maximum is EMAX+2 (9 for defaults).
- Throughput: the next accept is possible no earlier than the cycle after the output handshake, so one result per L+3 cycles minimum.
- `out_weight` is registered and holds its last value when `out_valid` = 0.
- Asserting `rst_n` mid-SEARCH or mid-DONE aborts immediately:
  - the pending result is discarded;
  - `out_valid` drops asynchronously;
  - there is no output after reset release until a new accept.

## Configuration
- `POT_ROUND_EN`:
  - Defined: round to nearest. At SEARCH exit with `mag[V-1]` = 1, `mag[V-2]` = 1 and cnt > 0, exp = cnt − 1 (magnitude ≥ 1.5·2^−cnt rounds up). Latency is unchanged, since it is still based on L.
  - Undefined: truncate, exp = cnt always.
- Clamp at EMAX is never rounded.

## Structure
- Shared package `pot_pkg`:
  - state enum (IDLE/SEARCH/DONE);
  - function `pot_emax(WEIGHT_BIT_WIDTH)`;
  - code-field helpers (sign index, exponent slice) shared with the PoT multiplier.
- No sub-module is needed: the FSM, shift register, counter and rounding fit in one module.

## Test plan
All scenarios use defaults V=8, W=4.
- `in_value` = 0x20 (0.25), accepted in c0 → `out_valid` in c0+4, `out_weight` = 4'b0010.
- `in_value` = 0xE0 (−0.25) → 4'b1010.
- `in_value` = 0x80 (−1) → 4'b1000 at latency 2.
- `in_value` = 0x00 → 4'b0111 at latency 9.
- `in_value` = 0x30 (0.375):
  - without `POT_ROUND_EN` → 4'b0010;
  - with it → 4'b0001.
- Hold `out_ready` low 5 cycles after `out_valid` → `out_weight` stable, `in_ready` = 0. Release → handshake, IDLE next cycle, then a new accept is possible.
- `in_value` = 0x01 (clamps to EMAX): drop `rst_n` in the 3rd SEARCH cycle → `out_valid` = 0 and `in_ready` = 1 after release, with no spurious output.
